// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//
// Three requesters share one 4-digit BCD display. An idle scheduler grants one
// requester by round-robin, latches and clamps its 14-bit value to 9999, and
// converts it to BCD with one double-dabble step per cycle. All four digits and
// the saturation flag are then updated together with a one-cycle ack. The
// committed value is kept on the display for HOLD_CYCLES cycles before the next
// grant is allowed.
//
// Ports
//   clk                      system clock, rising edge
//   rst_n                    asynchronous active-low reset
//   req[2:0]                 level requests, held until ack
//   value0/value1/value2     14-bit unsigned value per requester
//   grant[2:0]               one-hot, requester currently being served
//   ack                      one-cycle pulse when the granted value is committed
//   units/tens/hundreds/thousands  BCD digits of the last committed value
//   sat                      last committed value was clamped to 9999
//   busy                     state is not IDLE
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for any req; grant by round-robin on the next edge
// CONVERT | 14 double-dabble iterations, one per cycle
// COMMIT  | publish digits/sat, pulse ack, drop grant, remember requester
// HOLD    | keep the committed value on display for HOLD_CYCLES cycles
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [13:0] value0,
  input  logic [13:0] value1,
  input  logic [13:0] value2,
  output logic [2:0]  grant,
  output logic        ack,
  output logic [3:0]  units,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic        sat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam logic [3:0]  LAST_ITER   = 4'd13;
  // HOLD is entered with the counter at HOLD_CYCLES-1 and left when it reads
  // zero, so exactly HOLD_CYCLES cycles are spent there.
  localparam logic [26:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 27'(HOLD_CYCLES - 1) : 27'd0;

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic        ack_q, ack_d;
  logic [15:0] digits_q, digits_d;
  logic        sat_q, sat_d;
  logic        sat_pend_q, sat_pend_d;
  // {bcd[15:0], binary[13:0]} working register for double-dabble
  logic [29:0] shreg_q, shreg_d;
  logic [3:0]  iter_q, iter_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  sel_q, sel_d;
  logic [26:0] hold_q, hold_d;

  logic [1:0]  rr_sel;
  logic [13:0] rr_value;
  logic        rr_over;

  // Search starts one past the last served requester and wraps 2 -> 0.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // One double-dabble iteration: correct every BCD digit >= 5, then shift.
  function automatic logic [29:0] dd_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[28:0], 1'b0};
  endfunction

  always_comb begin
    rr_sel = rr_pick(req, last_q);
    case (rr_sel)
      2'd0:    rr_value = value0;
      2'd1:    rr_value = value1;
      default: rr_value = value2;
    endcase
    rr_over = (rr_value > MAX_DISPLAY);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = 1'b0;
    digits_d   = digits_q;
    sat_d      = sat_q;
    sat_pend_d = sat_pend_q;
    shreg_d    = shreg_q;
    iter_d     = iter_q;
    last_d     = last_q;
    sel_d      = sel_q;
    hold_d     = hold_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d      = rr_sel;
          grant_d    = 3'b001 << rr_sel;
          shreg_d    = {16'd0, (rr_over ? MAX_DISPLAY : rr_value)};
          sat_pend_d = rr_over;
          iter_d     = 4'd0;
          state_d    = CONVERT;
        end
      end

      CONVERT: begin
        shreg_d = dd_step(shreg_q);
        iter_d  = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        digits_d = shreg_q[29:14];
        sat_d    = sat_pend_q;
        ack_d    = 1'b1;
        grant_d  = 3'b000;
        last_d   = sel_q;
        hold_d   = HOLD_LOAD;
        state_d  = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      end

      HOLD: begin
        if (hold_q == 27'd0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - 27'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 3'b000;
      ack_q      <= 1'b0;
      digits_q   <= 16'd0;
      sat_q      <= 1'b0;
      sat_pend_q <= 1'b0;
      shreg_q    <= 30'd0;
      iter_q     <= 4'd0;
      last_q     <= 2'd2;
      sel_q      <= 2'd0;
      hold_q     <= 27'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      digits_q   <= digits_d;
      sat_q      <= sat_d;
      sat_pend_q <= sat_pend_d;
      shreg_q    <= shreg_d;
      iter_q     <= iter_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign ack       = ack_q;
  assign units     = digits_q[3:0];
  assign tens      = digits_q[7:4];
  assign hundreds  = digits_q[11:8];
  assign thousands = digits_q[15:12];
  assign sat       = sat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 100000000, meaning the minimum number of clk cycles each committed value stays displayed before the next grant; legal range 0..2^27-1.
REQ-002 The block SHALL have port clk  input  1  system clock; all sequential logic is on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port req  input  3  per-requester display request, level, held high until ack.
REQ-005 The block SHALL have ports value0, value1, value2  input  14 each  unsigned binary value offered by each requester.
REQ-006 The block SHALL have port grant  output  3  one-hot, registered, identifying the requester being served.
REQ-007 The block SHALL have port ack  output  1  registered one-cycle pulse when the granted value is committed.
REQ-008 The block SHALL have ports units, tens, hundreds, thousands  output  4 each  registered BCD digits for the 4-digit display driver.
REQ-009 The block SHALL have port sat  output  1  registered; high when the last committed value was clamped.
REQ-010 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, CONVERT, COMMIT, HOLD.
REQ-012 In IDLE, when req is not all-zero at a rising edge, the block SHALL select one requester by round-robin, starting at the index after last_grant and wrapping 2->0.
REQ-013 On that grant edge E, the block SHALL latch the selected value, set the matching grant bit, and enter CONVERT with the iteration counter at 0.
REQ-014 A latched value >9999 SHALL be clamped to 9999 and internal sat_pending SHALL be set; otherwise sat_pending SHALL be cleared.
REQ-015 CONVERT SHALL perform one shift-add-3 (double-dabble) iteration per cycle over 14 bits, occupying edges E+1..E+14, then enter COMMIT.
REQ-016 At edge E+15 (COMMIT), the block SHALL update all four digits and sat simultaneously, pulse ack for exactly one cycle, clear grant, update last_grant, and enter HOLD.
REQ-017 Digit outputs SHALL never show partially converted data; they change only at COMMIT or reset.
REQ-018 HOLD SHALL last exactly HOLD_CYCLES cycles and then enter IDLE; with HOLD_CYCLES=0, COMMIT SHALL go directly to IDLE.
REQ-019 Requests arriving outside IDLE SHALL be ignored until IDLE; no queuing beyond the req level itself.
REQ-020 Deassertion of the granted req during CONVERT/COMMIT SHALL NOT abort the transaction; the latched value is committed and acked.
REQ-021 Changes to value inputs after the grant edge SHALL NOT affect the committed result.
REQ-022 Simultaneous requests SHALL be resolved solely by round-robin order; a requester holding req continuously SHALL be served at least once every 3 transactions.
REQ-023 The HOLD counter SHALL be 27 bits wide and SHALL NOT wrap within a single HOLD period.

Reset
REQ-024 While rst_n is low, state SHALL be IDLE; grant=000, ack=0, sat=0, busy=0, all digits=0, last_grant=2 (requester 0 has first priority).
REQ-025 Reset asserted mid-transaction SHALL abort immediately with no ack and digits forced to 0.
REQ-026 After rst_n rises, the first grant SHALL occur no earlier than the first rising edge following deassertion.

Verification (HOLD_CYCLES=4 unless stated)
REQ-027 Single request: req=001, value0=1234 at edge E -> grant=001 from E to E+15, at E+15 digits 1,2,3,4 (thousands..units), ack one cycle, sat=0, busy low at E+20.
REQ-028 Saturation: req=010, value1=16383 -> digits 9,9,9,9, sat=1; next value1=7 -> digits 0,0,0,7, sat=0.
REQ-029 Round-robin: req=111 held, ack each time -> grant order 001, 010, 100, 001; each transaction spaced exactly 20 cycles.
REQ-030 Mid-flight change: value0 changed from 42 to 9000 at E+5 -> committed digits 0,0,4,2.
REQ-031 Reset mid-CONVERT at E+7 -> grant=000, digits 0, no ack ever for that transaction, busy=0.
REQ-032 HOLD_CYCLES=0 with req=001 held -> back-to-back commits every 16 cycles, ack pulses never merge.
